// File: rtl/emc_ext_bus_ctrl_if.sv
// rtl/emc_ext_bus_ctrl_if.sv - core request and pad signal bundle for emc_ext_bus_ctrl
//
// Purpose: groups the core-side request/response handshake and the port-pad bus
//          (P0 data, P2/P4 address, P3 strobes, PSEN) of the external bus controller.
// Ports (members):
//   core side : ebc_req_i, ebc_cmd_i[1:0], ebc_addr_i[15:0], ebc_wdata_i[7:0],
//               ebc_ptr_load_i, ebc_use_ptr_i, ebc_busy_o, ebc_done_o, ebc_err_o,
//               ebc_rdata_o[7:0], ebc_ptr_o[15:0]
//   pad side  : p0_y_i[7:0], p0_a_o[7:0], p0_en_o[7:0], p2_a_o[7:0], p4_a_o[7:0],
//               wr_b_o, rd_b_o, psen_b_o
//   modports  : slave (the controller), master (core plus pads/external RAM)
interface emc_ext_bus_ctrl_if;
   logic        ebc_req_i;
   logic [1:0]  ebc_cmd_i;
   logic [15:0] ebc_addr_i;
   logic [7:0]  ebc_wdata_i;
   logic        ebc_ptr_load_i;
   logic        ebc_use_ptr_i;
   logic        ebc_busy_o;
   logic        ebc_done_o;
   logic        ebc_err_o;
   logic [7:0]  ebc_rdata_o;
   logic [15:0] ebc_ptr_o;
   logic [7:0]  p0_y_i;
   logic [7:0]  p0_a_o;
   logic [7:0]  p0_en_o;
   logic [7:0]  p2_a_o;
   logic [7:0]  p4_a_o;
   logic        wr_b_o;
   logic        rd_b_o;
   logic        psen_b_o;

   modport slave (
      input  ebc_req_i, ebc_cmd_i, ebc_addr_i, ebc_wdata_i, ebc_ptr_load_i, ebc_use_ptr_i, p0_y_i,
      output ebc_busy_o, ebc_done_o, ebc_err_o, ebc_rdata_o, ebc_ptr_o,
             p0_a_o, p0_en_o, p2_a_o, p4_a_o, wr_b_o, rd_b_o, psen_b_o
   );

   modport master (
      output ebc_req_i, ebc_cmd_i, ebc_addr_i, ebc_wdata_i, ebc_ptr_load_i, ebc_use_ptr_i, p0_y_i,
      input  ebc_busy_o, ebc_done_o, ebc_err_o, ebc_rdata_o, ebc_ptr_o,
             p0_a_o, p0_en_o, p2_a_o, p4_a_o, wr_b_o, rd_b_o, psen_b_o
   );
endinterface

// File: rtl/emc_ext_bus_ctrl.sv
// rtl/emc_ext_bus_ctrl.sv - EMC08 external bus controller (code fetch, MOVX read/write)
//
// Purpose: turns core req/cmd/addr requests into non-multiplexed external memory
//          cycles: IDLE -> ADDR -> STROBE (WAIT_CYCLES+1) -> RECOVER -> IDLE.
// Ports:
//   ebc_clock_i : system clock
//   ebc_reset_i : asynchronous reset, active-low
//   bus         : emc_ext_bus_ctrl_if.slave (core handshake and port pads)
// Optional feature: define EMC_EBC_AUTOINC_EN for the auto-incrementing address
//   pointer (ebc_ptr_load_i / ebc_use_ptr_i); otherwise ebc_ptr_o stays 0x0000.
module emc_ext_bus_ctrl #(
   parameter int WAIT_CYCLES = 1,
   parameter int ADDR_W      = 16
) (
   input  logic              ebc_clock_i,
   input  logic              ebc_reset_i,
   emc_ext_bus_ctrl_if.slave bus
);
   typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_STROBE, ST_RECOVER} state_t;

   localparam logic [2:0] WAIT_INIT = 3'(WAIT_CYCLES);
   localparam logic [1:0] CMD_CODE  = 2'b00;
   localparam logic [1:0] CMD_RD    = 2'b01;
   localparam logic [1:0] CMD_WR    = 2'b10;
   localparam logic [1:0] CMD_RSVD  = 2'b11;
   localparam logic [ADDR_W-1:0] PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

   state_t            state_q, state_d;
   logic [2:0]        cnt_q, cnt_d;
   logic [1:0]        cmd_q, cmd_d;
   logic              use_ptr_q, use_ptr_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic [7:0]        rdata_q, rdata_d;
   logic [7:0]        p0_a_q, p0_a_d;
   logic [7:0]        p0_en_q, p0_en_d;
   logic [7:0]        p2_a_q, p2_a_d;
   logic [7:0]        p4_a_q, p4_a_d;
   logic              wr_b_q, wr_b_d;
   logic              rd_b_q, rd_b_d;
   logic              psen_b_q, psen_b_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;

   logic              ptr_load;
   logic              use_ptr;
   logic [ADDR_W-1:0] acc_addr;

`ifdef EMC_EBC_AUTOINC_EN
   assign ptr_load = bus.ebc_ptr_load_i;
   assign use_ptr  = bus.ebc_use_ptr_i;
`else
   // Pointer controls have no effect; ptr_q never leaves its reset value.
   logic unused_ptr_ctrl;
   assign unused_ptr_ctrl = bus.ebc_ptr_load_i ^ bus.ebc_use_ptr_i;
   assign ptr_load = 1'b0;
   assign use_ptr  = 1'b0;
`endif

   assign acc_addr = use_ptr ? ptr_q : bus.ebc_addr_i;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      cmd_d     = cmd_q;
      use_ptr_d = use_ptr_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      err_d     = 1'b0;
      rdata_d   = rdata_q;
      p0_a_d    = p0_a_q;
      p0_en_d   = p0_en_q;
      p2_a_d    = p2_a_q;
      p4_a_d    = p4_a_q;
      wr_b_d    = wr_b_q;
      rd_b_d    = rd_b_q;
      psen_b_d  = psen_b_q;
      ptr_d     = ptr_q;

      unique case (state_q)
         ST_IDLE: begin
            // A pointer load wins over a request presented in the same cycle.
            if (ptr_load) begin
               ptr_d = bus.ebc_addr_i;
            end else if (bus.ebc_req_i) begin
               if (bus.ebc_cmd_i == CMD_RSVD) begin
                  err_d = 1'b1;
               end else begin
                  cmd_d     = bus.ebc_cmd_i;
                  use_ptr_d = use_ptr;
                  busy_d    = 1'b1;
                  // Address and write data go out on the edge into ADDR so they
                  // are stable a full cycle before any strobe falls.
                  p2_a_d    = acc_addr[15:8];
                  p4_a_d    = acc_addr[7:0];
                  if (bus.ebc_cmd_i == CMD_WR) begin
                     p0_a_d  = bus.ebc_wdata_i;
                     p0_en_d = 8'hFF;
                  end
                  state_d = ST_ADDR;
               end
            end
         end
         ST_ADDR: begin
            cnt_d    = WAIT_INIT;
            psen_b_d = (cmd_q != CMD_CODE);
            rd_b_d   = (cmd_q != CMD_RD);
            wr_b_d   = (cmd_q != CMD_WR);
            state_d  = ST_STROBE;
         end
         ST_STROBE: begin
            if (cnt_q == 3'd0) begin
               psen_b_d = 1'b1;
               rd_b_d   = 1'b1;
               wr_b_d   = 1'b1;
               done_d   = 1'b1;
               if (cmd_q != CMD_WR) begin
                  rdata_d = bus.p0_y_i;
               end
               state_d = ST_RECOVER;
            end else begin
               cnt_d = cnt_q - 3'd1;
            end
         end
         ST_RECOVER: begin
            busy_d  = 1'b0;
            p0_en_d = 8'h00;
            p0_a_d  = 8'hFF;
            if (use_ptr_q) begin
               ptr_d = ptr_q + PTR_ONE;
            end
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Asynchronous reset lets the strobes rise and P0 release immediately.
   always_ff @(posedge ebc_clock_i or negedge ebc_reset_i) begin
      if (!ebc_reset_i) begin
         state_q   <= ST_IDLE;
         cnt_q     <= 3'd0;
         cmd_q     <= CMD_CODE;
         use_ptr_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         rdata_q   <= 8'h00;
         p0_a_q    <= 8'hFF;
         p0_en_q   <= 8'h00;
         p2_a_q    <= 8'h00;
         p4_a_q    <= 8'h00;
         wr_b_q    <= 1'b1;
         rd_b_q    <= 1'b1;
         psen_b_q  <= 1'b1;
         ptr_q     <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         cmd_q     <= cmd_d;
         use_ptr_q <= use_ptr_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         err_q     <= err_d;
         rdata_q   <= rdata_d;
         p0_a_q    <= p0_a_d;
         p0_en_q   <= p0_en_d;
         p2_a_q    <= p2_a_d;
         p4_a_q    <= p4_a_d;
         wr_b_q    <= wr_b_d;
         rd_b_q    <= rd_b_d;
         psen_b_q  <= psen_b_d;
         ptr_q     <= ptr_d;
      end
   end

   assign bus.ebc_busy_o  = busy_q;
   assign bus.ebc_done_o  = done_q;
   assign bus.ebc_err_o   = err_q;
   assign bus.ebc_rdata_o = rdata_q;
   assign bus.ebc_ptr_o   = ptr_q;
   assign bus.p0_a_o      = p0_a_q;
   assign bus.p0_en_o     = p0_en_q;
   assign bus.p2_a_o      = p2_a_q;
   assign bus.p4_a_o      = p4_a_q;
   assign bus.wr_b_o      = wr_b_q;
   assign bus.rd_b_o      = rd_b_q;
   assign bus.psen_b_o    = psen_b_q;
endmodule
